// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register bank.
package jk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK   = 2'b00;
    localparam mode_t MODE_UP   = 2'b01;
    localparam mode_t MODE_DN   = 2'b10;
    localparam mode_t MODE_HOLD = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to a per-bit value.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_r;

    // Classic JK next-state; reset and enable gate the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= rst_val;
        end else if (en) begin
            case ({j, k})
                2'b00:   q_r <= q_r;
                2'b01:   q_r <= 1'b0;
                2'b10:   q_r <= 1'b1;
                2'b11:   q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH-bit JK register bank that doubles as a synchronous up/down counter.
// Optional macro JK_SATURATE_EN makes the count modes saturate instead of wrapping.
module jk_counter_reg
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] up_tog_s;
    logic [WIDTH-1:0] dn_tog_s;
    logic [WIDTH-1:0] cell_j_s;
    logic [WIDTH-1:0] cell_k_s;
    logic             tc_s;
    logic             wrap_r;

    assign tc_s = en & (((mode == MODE_UP) & (&q_s)) | ((mode == MODE_DN) & ~(|q_s)));

    // Carry chains: a bit toggles once every lower bit is 1 (up) or 0 (down).
    always_comb begin
        logic up_run;
        logic dn_run;
        up_tog_s = '0;
        dn_tog_s = '0;
        up_run   = 1'b1;
        dn_run   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_tog_s[i] = up_run;
            dn_tog_s[i] = dn_run;
            up_run      = up_run & q_s[i];
            dn_run      = dn_run & ~q_s[i];
        end
`ifdef JK_SATURATE_EN
        // At the limit no bit toggles, so the count sticks.
        if (tc_s) begin
            up_tog_s = '0;
            dn_tog_s = '0;
        end else begin
            up_tog_s = up_tog_s;
            dn_tog_s = dn_tog_s;
        end
`endif
    end

    // Steer J/K into the cells; external j/k only reach them in JK mode.
    always_comb begin
        cell_j_s = '0;
        cell_k_s = '0;
        if (!en) begin
            cell_j_s = '0;
            cell_k_s = '0;
        end else begin
            case (mode)
                MODE_JK: begin
                    cell_j_s = j;
                    cell_k_s = k;
                end
                MODE_UP: begin
                    cell_j_s = up_tog_s;
                    cell_k_s = up_tog_s;
                end
                MODE_DN: begin
                    cell_j_s = dn_tog_s;
                    cell_k_s = dn_tog_s;
                end
                MODE_HOLD: begin
                    cell_j_s = '0;
                    cell_k_s = '0;
                end
                default: begin
                    cell_j_s = '0;
                    cell_k_s = '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RST_VAL[gi]),
            .en      (en),
            .j       (cell_j_s[gi]),
            .k       (cell_k_s[gi]),
            .q       (q_s[gi])
        );
    end

    // Wrap pulse: high for the cycle after the counter passes its terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_r <= 1'b0;
        end else begin
`ifdef JK_SATURATE_EN
            wrap_r <= 1'b0;
`else
            wrap_r <= tc_s;
`endif
        end
    end

    assign q    = q_s;
    assign tc   = tc_s;
    assign wrap = wrap_r;

endmodule
